// File: rtl/alu_pkg.sv
// Shared opcode, flag and helper definitions for the pipelined ARM datapath ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_MOV = 4'b0000,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_AND = 4'b0100,
      OP_ORR = 4'b0101,
      OP_EOR = 4'b0110,
      OP_LSL = 4'b0111,
      OP_LSR = 4'b1000,
      OP_ADC = 4'b1001
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   localparam logic [3:0] ALU_OP_MOV = 4'b0000;
   localparam logic [3:0] ALU_OP_ADD = 4'b0010;
   localparam logic [3:0] ALU_OP_SUB = 4'b0011;
   localparam logic [3:0] ALU_OP_AND = 4'b0100;
   localparam logic [3:0] ALU_OP_ORR = 4'b0101;
   localparam logic [3:0] ALU_OP_EOR = 4'b0110;
   localparam logic [3:0] ALU_OP_LSL = 4'b0111;
   localparam logic [3:0] ALU_OP_LSR = 4'b1000;
   localparam logic [3:0] ALU_OP_ADC = 4'b1001;

   // Ops whose C/V come from the adder; every other op preserves C/V.
   function automatic logic is_arith(input alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: ripple-carry adder with B inversion for subtract,
// logic ops, logical shifts, and NZCV generation.
module alu_core
   import alu_pkg::*;
#(
   parameter  int WIDTH = 64,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   input  logic             c_in,
   input  logic             v_in,
   output logic [WIDTH-1:0] result,
   output nzcv_t            nzcv
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   logic [SHW-1:0]   sh;
   logic             arith;

   always_comb begin
      b_eff    = (op == OP_SUB) ? ~b : b;
      carry    = '0;
      sum      = '0;
      carry[0] = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? c_in : 1'b0);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
         carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
      end
   end

   always_comb begin
      sh    = b[SHW-1:0];
      arith = is_arith(op);
      case (op)
         OP_MOV:                 result = b;
         OP_ADD, OP_SUB, OP_ADC: result = sum;
         OP_AND:                 result = a & b;
         OP_ORR:                 result = a | b;
         OP_EOR:                 result = a ^ b;
         OP_LSL:                 result = a << sh;
         OP_LSR:                 result = a >> sh;
         default:                result = '0;
      endcase
      nzcv.n = result[WIDTH-1];
      nzcv.z = (result == '0);
      nzcv.c = arith ? carry[WIDTH] : c_in;
      nzcv.v = arith ? (carry[WIDTH] ^ carry[WIDTH-1]) : v_in;
   end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready pipelined ALU with an architectural NZCV register.
// Stage 1 registers the operand beat; stage 2 registers the alu_core result.
module pipelined_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_setf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic [3:0]       flags
);

   logic             s1_valid;
   alu_op_e          s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_setf;
   nzcv_t            flags_q;
   logic [WIDTH-1:0] core_result;
   nzcv_t            core_nzcv;
   logic             accept;
   logic             s2_load;

   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign flags    = flags_q;

   // ADC reads the committed flag register directly: a preceding setf op
   // has already written it on the edge that loaded its result.
   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .c_in   (flags_q.c),
      .v_in   (flags_q.v),
      .result (core_result),
      .nzcv   (core_nzcv)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s1_op      <= OP_MOV;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_setf    <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         flags_q    <= '0;
      end else begin
         if (accept) begin
            s1_op   <= alu_op_e'(in_op);
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_setf <= in_setf;
         end
         if (accept)       s1_valid <= 1'b1;
         else if (s2_load) s1_valid <= 1'b0;

         if (s2_load) begin
            out_valid  <= 1'b1;
            out_result <= core_result;
            out_flags  <= core_nzcv;
            if (s1_setf) flags_q <= core_nzcv;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu (WIDTH=64) with an in-order reference model
// and scoreboard, plus literal expectations for the key ARM flag cases.
module tb_pipelined_alu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_setf;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  flags;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] res;
      logic [3:0]  of;
      logic [3:0]  fl;
      int          acc_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  m_flags = '0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   logic [63:0] last_result = '0;
   logic [3:0]  last_oflags = '0;
   int          last_lat = 0;

   logic [3:0] bp_ops [10] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h0, 4'hF};

   pipelined_alu #(.WIDTH(64)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_setf    (in_setf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference semantics: exact unsigned/signed arithmetic, flags applied in program order.
   function automatic void model_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                    input logic setf, output logic [63:0] r, output logic [3:0] of);
      logic [64:0]        u;
      logic signed [65:0] sa, sb, s;
      logic               c, v, arith;
      sa = {{2{a[63]}}, a};
      sb = {{2{b[63]}}, b};
      s  = '0;
      u  = '0;
      c  = m_flags[1];
      v  = m_flags[0];
      arith = 1'b1;
      r  = '0;
      case (op)
         4'h2: begin u = {1'b0, a} + {1'b0, b}; s = sa + sb; end
         4'h3: begin u = {1'b0, a} - {1'b0, b}; s = sa - sb; end
         4'h9: begin
            u = {1'b0, a} + {1'b0, b} + {64'b0, m_flags[1]};
            s = sa + sb;
            if (m_flags[1]) s = s + 66'sd1;
         end
         default: arith = 1'b0;
      endcase
      if (arith) begin
         r = u[63:0];
         c = (op == 4'h3) ? (a >= b) : u[64];
         v = (s != {{2{r[63]}}, r});
      end else begin
         case (op)
            4'h0: r = b;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = a << b[5:0];
            4'h8: r = a >> b[5:0];
            default: r = '0;
         endcase
      end
      of = {r[63], (r == 64'd0), c, v};
      if (setf) m_flags = of;
   endfunction

   // Scoreboard: every cycle with out_valid is compared against the queue head.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] r;
      logic [3:0]  of;
      cyc++;
      if (!reset_n) begin
         exp_q.delete();
         m_flags = '0;
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out_valid: got result %h with no beat expected", out_result);
            end else begin
               e = exp_q[0];
               chk("model_result", out_result, e.res);
               chk("model_out_flags", {60'b0, out_flags}, {60'b0, e.of});
               chk("model_flags", {60'b0, flags}, {60'b0, e.fl});
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  last_result = out_result;
                  last_oflags = out_flags;
                  last_lat    = cyc - e.acc_cyc;
                  pop_cnt++;
               end
            end
         end
         if (in_valid && in_ready) begin
            model_op(in_op, in_a, in_b, in_setf, r, of);
            e.res = r;
            e.of = of;
            e.fl = m_flags;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            acc_cnt++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat was accepted.
   task automatic push_beat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic setf);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_setf  = setf;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got in_ready=0 for 50 cycles expected acceptance");
      end
   endtask

   task automatic drain();
      bit empty = 1'b0;
      for (int n = 0; n < 60 && !empty; n++) begin
         @(negedge clk);
         #1;
         empty = (exp_q.size() == 0);
      end
      if (!empty) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200us");
      $fatal(1);
   end

   initial begin
      int acc0, pop0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_setf   = 1'b0;
      out_ready = 1'b1;

      // 1. Reset and basic ops
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_flags", {60'b0, out_flags}, 64'd0);
      chk("rst_flags", {60'b0, flags}, 64'd0);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rel_flags", {60'b0, flags}, 64'd0);

      push_beat(4'h2, 64'd5, 64'd7, 1'b1);
      drain();
      chk("add5_7_result", last_result, 64'd12);
      chk("add5_7_nzcv", {60'b0, last_oflags}, 64'h0);
      chk("add5_7_latency", 64'(last_lat), 64'd2);

      // 2. Subtract flags
      push_beat(4'h3, 64'd3, 64'd5, 1'b1);
      drain();
      chk("sub3_5_result", last_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub3_5_nzcv", {60'b0, last_oflags}, 64'b1000);
      push_beat(4'h3, 64'd5, 64'd5, 1'b1);
      drain();
      chk("sub5_5_result", last_result, 64'd0);
      chk("sub5_5_nzcv", {60'b0, last_oflags}, 64'b0110);

      // 3. Overflow and back-to-back ADC
      push_beat(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      drain();
      chk("add_ovf_result", last_result, 64'h8000_0000_0000_0000);
      chk("add_ovf_nzcv", {60'b0, last_oflags}, 64'b1001);
      push_beat(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      push_beat(4'h9, 64'd1, 64'd1, 1'b0);
      drain();
      chk("adc_result", last_result, 64'd3);
      chk("adc_flags_held", {60'b0, flags}, 64'b0110);

      // 4. Shifts
      push_beat(4'h7, 64'd1, 64'd63, 1'b1);
      drain();
      chk("lsl63_result", last_result, 64'h8000_0000_0000_0000);
      chk("lsl_nzcv_cv_kept", {60'b0, last_oflags}, 64'b1010);
      push_beat(4'h8, 64'h1234, 64'd64, 1'b0);
      drain();
      chk("lsr_sh0_result", last_result, 64'h1234);

      // 5. Backpressure: 10 beats, consumer stalled at the start
      acc0 = acc_cnt;
      pop0 = pop_cnt;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               logic [63:0] idx;
               idx = 64'(i);
               push_beat(bp_ops[i], 64'h55 + idx * 64'h100, idx + 64'd1, idx[0]);
            end
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
            chk("bp_accepts_before_stall", 64'(acc_cnt - acc0), 64'd2);
            repeat (2) begin
               @(negedge clk);
               chk("bp_held_result", out_result, 64'h56);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_accept_count", 64'(acc_cnt - acc0), 64'd10);
      chk("bp_pop_count", 64'(pop_cnt - pop0), 64'd10);

      // 6. Reset mid-stream with two beats in flight
      out_ready = 1'b0;
      push_beat(4'h3, 64'd3, 64'd5, 1'b1);
      push_beat(4'h2, 64'd1, 64'd1, 1'b0);
      chk("mid_flags_before_reset", {60'b0, flags}, 64'b1000);
      chk("mid_out_valid_before_reset", {63'b0, out_valid}, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("mid_rst_flags", {60'b0, flags}, 64'd0);
      chk("mid_rst_out_result", out_result, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_stale", {63'b0, out_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
      push_beat(4'h2, 64'd2, 64'd2, 1'b0);
      drain();
      chk("post_rst_add", last_result, 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
